crop_video_window_ctrl: RTL and testbench

//  Frame-synchronous crop controller on the AXI4-Stream video path, between the video source and the crop sink interface.

---
 rtl/crop_video_pkg.sv | 21 ++
 rtl/crop_video_xy_cnt.sv | 67 ++++++
 rtl/crop_video_window_ctrl.sv | 153 +++++++++++++++
 tb/tb_crop_video_window_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crop_video_pkg.sv
// Shared types and defaults for the AXI4-Stream video crop controller.
// Holds the FSM state enum, default widths and the window config bundle.
package crop_video_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int X_W_DEF    = 12;
  localparam int Y_W_DEF    = 12;

  typedef enum logic {
    WAIT_SOF,
    ACTIVE
  } state_t;

  typedef struct packed {
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
    logic [X_W_DEF-1:0] w;
    logic [Y_W_DEF-1:0] h;
  } cfg_t;

endpackage

// File: rtl/crop_video_xy_cnt.sv
// Pixel x/y tracker with saturation and window membership test.
// CROP_VIDEO_STATUS_EN adds a line_open flag used by the status logic.
module crop_video_xy_cnt #(
  parameter int X_W = 12,
  parameter int Y_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           beat,
  input  logic           sof,
  input  logic           eol,
  input  logic [X_W-1:0] win_x,
  input  logic [X_W-1:0] win_w,
  input  logic [Y_W-1:0] win_y,
  input  logic [Y_W-1:0] win_h,
  output logic           in_window,
  output logic           at_right,
  output logic           at_bottom
`ifdef CROP_VIDEO_STATUS_EN
  ,
  output logic           line_open
`endif
);

  logic [X_W-1:0] x_q;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y_q;
  logic [Y_W-1:0] y;
  logic [X_W:0]   x_end;
  logic [Y_W:0]   y_end;

  // An SOF beat is always evaluated at (0,0)
  assign x = sof ? '0 : x_q;
  assign y = sof ? '0 : y_q;

  assign x_end = {1'b0, win_x} + {1'b0, win_w};
  assign y_end = {1'b0, win_y} + {1'b0, win_h};

  assign in_window = (x >= win_x) &&
                     ({1'b0, x} < x_end) &&
                     (y >= win_y) &&
                     ({1'b0, y} < y_end);

  assign at_right  = ({1'b0, x} == x_end - 1'b1);
  assign at_bottom = ({1'b0, y} == y_end - 1'b1) || (&y);

`ifdef CROP_VIDEO_STATUS_EN
  assign line_open = |x_q;
`endif

  // Advance coordinates on each accepted beat, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (beat) begin
      if (eol) begin
        x_q <= '0;
        y_q <= (&y) ? y : y + 1'b1;
      end else begin
        x_q <= (&x) ? x : x + 1'b1;
        y_q <= y;
      end
    end
  end

endmodule

// File: rtl/crop_video_window_ctrl.sv
// Frame-synchronous AXI4-Stream crop: shadows window cfg at SOF, keeps
// in-window pixels, regenerates SOF/EOL. Status via CROP_VIDEO_STATUS_EN.
module crop_video_window_ctrl
  import crop_video_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int X_W    = X_W_DEF,
  parameter int Y_W    = Y_W_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [X_W-1:0]    cfg_x,
  input  logic [Y_W-1:0]    cfg_y,
  input  logic [X_W-1:0]    cfg_w,
  input  logic [Y_W-1:0]    cfg_h,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [15:0]       frame_cnt,
  output logic              err_sticky
);

  state_t state;
  state_t state_n;
  cfg_t   pend;
  cfg_t   act;
  cfg_t   new_cfg;
  cfg_t   eff;
  logic   accept;
  logic   sof;
  logic   live;
  logic   keep;
  logic   first;
  logic   in_window;
  logic   at_right;
  logic   at_bottom;
`ifdef CROP_VIDEO_STATUS_EN
  logic   line_open;
  logic   started;
`endif

  assign s_axis_tready = aresetn & (~m_axis_tvalid | m_axis_tready);
  assign accept  = s_axis_tvalid & s_axis_tready;
  assign sof     = accept & s_axis_tuser;
  assign new_cfg = '{x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h};
  assign eff     = !sof ? act : (cfg_valid ? new_cfg : pend);
  assign live    = sof | (state == ACTIVE);
  assign keep    = accept & live & in_window;

  crop_video_xy_cnt #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_xy (
    .clk       (aclk),
    .rst_n     (aresetn),
    .beat      (accept),
    .sof       (sof),
    .eol       (s_axis_tlast),
    .win_x     (eff.x),
    .win_w     (eff.w),
    .win_y     (eff.y),
    .win_h     (eff.h),
    .in_window (in_window),
    .at_right  (at_right),
    .at_bottom (at_bottom)
`ifdef CROP_VIDEO_STATUS_EN
    ,
    .line_open (line_open)
`endif
  );

  // Pending cfg captured any time; active cfg only swapped at SOF
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pend <= '0;
      act  <= '0;
    end else begin
      if (cfg_valid) pend <= new_cfg;
      if (sof)       act  <= eff;
    end
  end

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= WAIT_SOF;
    else          state <= state_n;
  end

  // Next state: enter on SOF, leave once the window's last line ends
  always_comb begin
    state_n = state;
    if (accept && live) begin
      if (s_axis_tlast && at_bottom) state_n = WAIT_SOF;
      else                           state_n = ACTIVE;
    end
  end

  // Arms output SOF for the first kept beat of each frame
  always_ff @(posedge aclk) begin
    if (!aresetn)  first <= 1'b0;
    else if (sof)  first <= ~keep;
    else if (keep) first <= 1'b0;
  end

  // Single output register; stalls hold it via s_axis_tready
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= keep;
      if (keep) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tuser <= sof | first;
        m_axis_tlast <= at_right | s_axis_tlast;
      end
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef CROP_VIDEO_STATUS_EN
  // Frame counter and malformed-frame flag
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      started    <= 1'b0;
      frame_cnt  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (sof) begin
        started <= 1'b1;
        if (started) frame_cnt <= frame_cnt + 16'd1;
        if (started && line_open) err_sticky <= 1'b1;
      end
      if (keep && s_axis_tlast && !at_right) err_sticky <= 1'b1;
    end
  end
`else
  assign frame_cnt  = '0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_crop_video_window_ctrl.sv
// Directed bench for crop_video_window_ctrl: window table plus
// hand sequences for cfg shadowing, mid-frame SOF and mid-line reset.
module tb_crop_video_window_ctrl;

  logic        aclk;
  logic        aresetn;
  logic [11:0] cfg_x;
  logic [11:0] cfg_y;
  logic [11:0] cfg_w;
  logic [11:0] cfg_h;
  logic        cfg_valid;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [15:0] frame_cnt;
  logic        err_sticky;

  crop_video_window_ctrl dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_x         (cfg_x),
    .cfg_y         (cfg_y),
    .cfg_w         (cfg_w),
    .cfg_h         (cfg_h),
    .cfg_valid     (cfg_valid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_cnt     (frame_cnt),
    .err_sticky    (err_sticky)
  );

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  typedef struct {
    int cx;
    int cy;
    int cw;
    int ch;
    int fw;
    int fh;
    bit stall;
    int n;
  } vec_t;

  beat_t got[$];
  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    stall    = 0;
  bit    hold_v   = 0;
  beat_t hold_b;

  initial aclk = 0;
  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Sink ready: toggles every cycle when stalling, else held high
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = stall ? ~m_axis_tready : 1'b1;
    end
  end

  task automatic check(string name, logic [31:0] a, logic [31:0] r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, a, r);
    end
  endtask

  // Output monitor: capture transfers, verify stability while stalled
  always @(negedge aclk) begin
    if (hold_v && aresetn) begin
      checks++;
      if (!m_axis_tvalid || m_axis_tdata !== hold_b.d ||
          m_axis_tuser !== hold_b.u || m_axis_tlast !== hold_b.l) begin
        failures++;
        $display("FAIL stall_hold actual=%0h required=%0h",
                 m_axis_tdata, hold_b.d);
      end
    end
    hold_v   = aresetn && m_axis_tvalid && !m_axis_tready;
    hold_b.d = m_axis_tdata;
    hold_b.u = m_axis_tuser;
    hold_b.l = m_axis_tlast;
    if (aresetn && m_axis_tvalid && m_axis_tready)
      got.push_back('{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast});
  end

  function automatic logic [23:0] pix(int x, int y);
    return 24'(y * 4096 + x);
  endfunction

  task automatic send_beat(logic [23:0] d, logic u, logic l);
    bit ok = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge aclk);
      ok = s_axis_tready;
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=0 required=1");
    end
  endtask

  task automatic send_seg(int y, int x0, int x1, bit sof, bit eol);
    for (int x = x0; x <= x1; x++)
      send_beat(pix(x, y), sof && x == x0, eol && x == x1);
  endtask

  task automatic send_frame(int fw, int fh);
    for (int y = 0; y < fh; y++)
      send_seg(y, 0, fw - 1, y == 0, 1'b1);
  endtask

  task automatic set_cfg(int cx, int cy, int cw, int ch);
    cfg_x = 12'(cx);
    cfg_y = 12'(cy);
    cfg_w = 12'(cw);
    cfg_h = 12'(ch);
  endtask

  task automatic pulse_cfg(int cx, int cy, int cw, int ch);
    set_cfg(cx, cy, cw, ch);
    cfg_valid = 1'b1;
    @(posedge aclk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    stall = 0;
    repeat (6) @(posedge aclk);
    #1;
  endtask

  // Reference crop of a clean fw x fh frame
  task automatic model(int cx, int cy, int cw, int ch, int fw, int fh);
    bit first = 1;
    for (int y = 0; y < fh; y++)
      for (int x = 0; x < fw; x++)
        if (x >= cx && x < cx + cw && y >= cy && y < cy + ch) begin
          exp_q.push_back('{d: pix(x, y), u: first,
                            l: (x == cx + cw - 1) || (x == fw - 1)});
          first = 0;
        end
  endtask

  task automatic compare(string name);
    int n;
    check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({name, "_beat"}, {6'd0, got[i].d, got[i].u, got[i].l},
            {6'd0, exp_q[i].d, exp_q[i].u, exp_q[i].l});
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(negedge aclk);
    check("rst_tready_low", 32'(s_axis_tready), 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_outputs",
          {4'd0, m_axis_tdata, m_axis_tvalid, m_axis_tuser,
           m_axis_tlast, s_axis_tready},
          32'd1);
    check("rst_status", {15'd0, frame_cnt, err_sticky}, 32'd0);
    @(posedge aclk);
    #1;
  endtask

  vec_t vecs[7];
  int   exp_fc;
  int   exp_err;

  initial begin
    aresetn       = 1'b0;
    cfg_valid     = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    set_cfg(0, 0, 0, 0);

    vecs[0] = '{2, 1, 3, 2, 8, 4, 0, 6};
    vecs[1] = '{2, 1, 3, 2, 8, 4, 1, 6};
    vecs[2] = '{6, 0, 4, 1, 8, 4, 0, 2};
    vecs[3] = '{0, 0, 0, 2, 8, 4, 0, 0};
    vecs[4] = '{0, 0, 8, 4, 8, 4, 1, 32};
    vecs[5] = '{5, 2, 10, 10, 8, 4, 0, 6};
    vecs[6] = '{1, 3, 2, 1, 8, 4, 0, 2};

    repeat (2) @(posedge aclk);
    #1;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      pulse_cfg(vecs[i].cx, vecs[i].cy, vecs[i].cw, vecs[i].ch);
      got.delete();
      stall = vecs[i].stall;
      send_frame(vecs[i].fw, vecs[i].fh);
      drain();
      check("table_n", 32'(got.size()), 32'(vecs[i].n));
      model(vecs[i].cx, vecs[i].cy, vecs[i].cw, vecs[i].ch,
            vecs[i].fw, vecs[i].fh);
      compare("table");
    end

`ifdef CROP_VIDEO_STATUS_EN
    exp_fc  = 6;
    exp_err = 1;
`else
    exp_fc  = 0;
    exp_err = 0;
`endif
    check("table_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    check("table_err", 32'(err_sticky), 32'(exp_err));

    // New cfg mid-frame applies only from the next SOF
    pulse_cfg(2, 1, 3, 2);
    send_seg(0, 0, 7, 1, 1);
    pulse_cfg(0, 0, 4, 4);
    for (int y = 1; y < 4; y++) send_seg(y, 0, 7, 0, 1);
    send_frame(8, 4);
    drain();
    model(2, 1, 3, 2, 8, 4);
    model(0, 0, 4, 4, 8, 4);
    compare("shadow");

    // SOF injected mid-line 2 resyncs immediately
    do_reset();
    pulse_cfg(2, 1, 3, 2);
    got.delete();
    send_seg(0, 0, 7, 1, 1);
    send_seg(1, 0, 7, 0, 1);
    send_seg(2, 0, 3, 0, 0);
    send_frame(8, 4);
    drain();
    exp_q.push_back('{d: pix(2, 1), u: 1'b1, l: 1'b0});
    exp_q.push_back('{d: pix(3, 1), u: 1'b0, l: 1'b0});
    exp_q.push_back('{d: pix(4, 1), u: 1'b0, l: 1'b1});
    exp_q.push_back('{d: pix(2, 2), u: 1'b0, l: 1'b0});
    exp_q.push_back('{d: pix(3, 2), u: 1'b0, l: 1'b0});
    model(2, 1, 3, 2, 8, 4);
    compare("resync");
`ifdef CROP_VIDEO_STATUS_EN
    exp_fc  = 1;
    exp_err = 1;
`endif
    check("resync_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    check("resync_err", 32'(err_sticky), 32'(exp_err));

    // Reset mid-line, trailing beats dropped until next SOF
    do_reset();
    pulse_cfg(2, 1, 3, 2);
    send_seg(0, 0, 7, 1, 1);
    send_seg(1, 0, 3, 0, 0);
    do_reset();
    got.delete();
    send_seg(1, 4, 7, 0, 1);
    send_seg(2, 0, 7, 0, 1);
    send_seg(3, 0, 7, 0, 1);
    drain();
    check("post_rst_drop", 32'(got.size()), 32'd0);
    set_cfg(2, 1, 3, 2);
    cfg_valid = 1'b1;
    send_seg(0, 0, 0, 1, 0);
    cfg_valid = 1'b0;
    send_seg(0, 1, 7, 0, 1);
    for (int y = 1; y < 4; y++) send_seg(y, 0, 7, 0, 1);
    drain();
    model(2, 1, 3, 2, 8, 4);
    compare("post_rst");
    check("post_rst_status", {15'd0, frame_cnt, err_sticky}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
